// File: rtl/gs_column_sequencer.sv
// Column sequencer for classical Gram-Schmidt: per column, issue projection, wait datapath,
// hand X-P to the normaliser over req/ack, then write the normalised q column back.
module gs_column_sequencer #(
    parameter int M        = 3,
    parameter int N        = 3,
    parameter int PROJ_LAT = 2,
    parameter int KW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [KW-1:0] col_idx,
    output logic [N-1:0]  q_mask,
    output logic          proj_en,
    output logic          norm_req,
    input  logic          norm_ack,
    input  logic          norm_done,
    input  logic          norm_zero,
    output logic          q_we
);

    // Row count does not affect sequencing; it only travels with the datapath interface.
    localparam int NCOL = N + 0 * M;
    localparam int CW   = $clog2(PROJ_LAT + 1);
    localparam logic [KW-1:0] LAST = KW'(NCOL - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_PROJ,
        NORM_REQ,
        NORM_WAIT,
        WRITE,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    // Bit i set iff column i has already been orthogonalised.
    function automatic logic [N-1:0] mask_below(input logic [KW-1:0] k);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = (i < int'(k));
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            col_idx  <= '0;
            q_mask   <= '0;
            proj_en  <= 1'b0;
            norm_req <= 1'b0;
            q_we     <= 1'b0;
        end else begin
            proj_en <= 1'b0;
            q_we    <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ISSUE;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        col_idx <= '0;
                        q_mask  <= '0;
                        proj_en <= 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT_PROJ;
                    wait_cnt <= CW'(PROJ_LAT);
                end
                WAIT_PROJ: begin
                    // Leave on the last of PROJ_LAT wait cycles so the result is valid in NORM_REQ.
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt <= CW'(1)) begin
                        state    <= NORM_REQ;
                        norm_req <= 1'b1;
                    end
                end
                NORM_REQ: begin
                    if (norm_ack) begin
                        state    <= NORM_WAIT;
                        norm_req <= 1'b0;
                    end
                end
                NORM_WAIT: begin
                    if (norm_done) begin
                        if (norm_zero) begin
                            // Degenerate column: abandon the run without writing it.
                            state <= DONE;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= WRITE;
                            q_we  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (col_idx == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= ISSUE;
                        col_idx <= col_idx + 1'b1;
                        q_mask  <= mask_below(col_idx + 1'b1);
                        proj_en <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gs_column_sequencer.sv
// Bench for gs_column_sequencer: table of run scenarios with hand-derived strobe cycles,
// checked through an event scoreboard, plus reset/idle checks.
module tb_gs_column_sequencer;

    localparam int N  = 3;
    localparam int KW = $clog2(N);
    localparam logic [7:0] NA = 8'hFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [KW-1:0] col_idx;
    logic [N-1:0]  q_mask;
    logic          proj_en, norm_req, q_we;
    logic          norm_ack = 1'b0, norm_done = 1'b0, norm_zero = 1'b0;

    gs_column_sequencer #(.M(3), .N(N), .PROJ_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .col_idx(col_idx), .q_mask(q_mask), .proj_en(proj_en), .norm_req(norm_req),
        .norm_ack(norm_ack), .norm_done(norm_done), .norm_zero(norm_zero), .q_we(q_we)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][7:0] ack;      // extra req cycles before ack, per column
        logic [7:0]      zero_col;
        logic [7:0]      spur;     // cycle of a stray norm_done pulse
        logic [7:0]      xs0, xs1; // cycles of stray start pulses
        logic [2:0][7:0] pe, rql, rqh, we;
        logic [7:0]      done_c, busy_hi, err_c, rst_at, end_c;
    } vec_t;

    typedef struct {
        int kind; // 1 proj_en, 2 norm_req, 3 q_we, 4 done
        int cyc;
        int col;
    } ev_t;

    ev_t  evq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vt[6];
    logic [N-1:0] mask_exp[3];

    function automatic logic [2:0][7:0] t3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic pop_ev(input int vi, input int rel, input int kind);
        ev_t e;
        if (evq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL v%0d r%0d unexpected strobe kind %0d: got 1 want 0", vi, rel, kind);
        end else begin
            e = evq.pop_front();
            check($sformatf("v%0d r%0d event", vi, rel), 32'(kind * 256 + rel), 32'(e.kind * 256 + e.cyc));
            if (kind < 4 && e.col >= 0) begin
                check($sformatf("v%0d r%0d col_idx", vi, rel), 32'(col_idx), 32'(e.col));
                check($sformatf("v%0d r%0d q_mask", vi, rel), 32'(q_mask), 32'(mask_exp[e.col]));
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int   age;
        bit   dpend;
        bit   zpend;
        ev_t  e;
        evq = {};
        for (int c = 0; c < N; c++) begin
            if (v.pe[c] != NA) begin e.kind = 1; e.cyc = int'(v.pe[c]); e.col = c; evq.push_back(e); end
            if (v.rql[c] != NA)
                for (int t = int'(v.rql[c]); t <= int'(v.rqh[c]); t++) begin
                    e.kind = 2; e.cyc = t; e.col = c; evq.push_back(e);
                end
            if (v.we[c] != NA) begin e.kind = 3; e.cyc = int'(v.we[c]); e.col = c; evq.push_back(e); end
        end
        if (v.done_c != NA) begin e.kind = 4; e.cyc = int'(v.done_c); e.col = -1; evq.push_back(e); end

        age = 0; dpend = 0; zpend = 0;
        for (int rel = 0; rel <= int'(v.end_c); rel++) begin
            @(negedge clk);
            if (rel >= 1) begin
                if (proj_en)  pop_ev(vi, rel, 1);
                if (norm_req) pop_ev(vi, rel, 2);
                if (q_we)     pop_ev(vi, rel, 3);
                if (done)     pop_ev(vi, rel, 4);
                check($sformatf("v%0d r%0d busy", vi, rel), 32'(busy), 32'(rel <= int'(v.busy_hi)));
                check($sformatf("v%0d r%0d err", vi, rel), 32'(err),
                      32'(v.err_c != NA && rel >= int'(v.err_c)));
                if (v.rst_at != NA && rel == int'(v.rst_at) + 1)
                    check($sformatf("v%0d r%0d col/mask after rst", vi, rel), 32'({col_idx, q_mask}), 32'(0));
            end
            start = (rel == 0) || (rel == int'(v.xs0)) || (rel == int'(v.xs1));
            rst   = (v.rst_at != NA) && (rel == int'(v.rst_at));
            norm_done = 1'b0;
            norm_zero = 1'b0;
            if (dpend) begin norm_done = 1'b1; norm_zero = zpend; dpend = 0; end
            if (rel == int'(v.spur)) begin norm_done = 1'b1; norm_zero = 1'b1; end
            norm_ack = 1'b0;
            if (norm_req && !rst) begin
                age++;
                if (age > int'(v.ack[col_idx])) begin
                    norm_ack = 1'b1;
                    age = 0;
                    dpend = 1;
                    zpend = (32'(col_idx) == 32'(v.zero_col));
                end
            end
        end
        check($sformatf("v%0d leftover events", vi), 32'(evq.size()), 32'(0));
        start = 0; rst = 0; norm_ack = 0; norm_done = 0; norm_zero = 0;
    endtask

    initial begin
        mask_exp[0] = 3'b000; mask_exp[1] = 3'b001; mask_exp[2] = 3'b011;

        // nominal: same-cycle ack, done one cycle later
        vt[0] = '{ack: t3(0,0,0), zero_col: NA, spur: NA, xs0: NA, xs1: NA,
                  pe: t3(1,7,13), rql: t3(4,10,16), rqh: t3(4,10,16), we: t3(6,12,18),
                  done_c: 8'd19, busy_hi: 8'd18, err_c: NA, rst_at: NA, end_c: 8'd28};
        // column 1 ack delayed by 3 cycles
        vt[1] = '{ack: t3(0,3,0), zero_col: NA, spur: NA, xs0: NA, xs1: NA,
                  pe: t3(1,7,16), rql: t3(4,10,19), rqh: t3(4,13,19), we: t3(6,15,21),
                  done_c: 8'd22, busy_hi: 8'd21, err_c: NA, rst_at: NA, end_c: 8'd30};
        // degenerate column 1
        vt[2] = '{ack: t3(0,0,0), zero_col: 8'd1, spur: NA, xs0: NA, xs1: NA,
                  pe: t3(1,7,255), rql: t3(4,10,255), rqh: t3(4,10,255), we: t3(6,255,255),
                  done_c: 8'd12, busy_hi: 8'd11, err_c: 8'd12, rst_at: NA, end_c: 8'd20};
        // stray starts (busy, DONE) and stray norm_done in WAIT_PROJ; also clears err
        vt[3] = '{ack: t3(0,0,0), zero_col: NA, spur: 8'd8, xs0: 8'd3, xs1: 8'd19,
                  pe: t3(1,7,13), rql: t3(4,10,16), rqh: t3(4,10,16), we: t3(6,12,18),
                  done_c: 8'd19, busy_hi: 8'd18, err_c: NA, rst_at: NA, end_c: 8'd28};
        // reset during WAIT_PROJ of column 1
        vt[4] = '{ack: t3(0,0,0), zero_col: NA, spur: NA, xs0: NA, xs1: NA,
                  pe: t3(1,7,255), rql: t3(4,255,255), rqh: t3(4,255,255), we: t3(6,255,255),
                  done_c: NA, busy_hi: 8'd8, err_c: NA, rst_at: 8'd8, end_c: 8'd14};
        vt[5] = vt[0];

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle %0d outputs", i),
                  32'({busy, done, err, col_idx, q_mask, proj_en, norm_req, q_we}), 32'(0));
        end

        for (int vi = 0; vi < 6; vi++) run_vec(vt[vi], vi);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
